// File: rtl/pll_phase_shift_responder_if.sv
// rtl/pll_phase_shift_responder_if.sv - PLL dynamic phase-shift handshake bundle
// master = phase-shift controller, slave = PLL responder model
interface pll_phase_shift_responder_if #(
  parameter int N_COUNTERS = 5,
  parameter int TAP_W      = 8
);
  logic                        phase_en;
  logic                        updn;
  logic [4:0]                  cntsel;
  logic                        locked;
  logic                        phase_done;
  logic [N_COUNTERS*TAP_W-1:0] taps;
  logic                        err;

  modport master (
    output phase_en, updn, cntsel,
    input  locked, phase_done, taps, err
  );

  modport slave (
    input  phase_en, updn, cntsel,
    output locked, phase_done, taps, err
  );
endinterface

// File: rtl/pll_phase_shift_responder.sv
// rtl/pll_phase_shift_responder.sv - PLL phase-shift port model: lock, busy window, per-counter taps
// Optional sticky protocol-error flag built only when PLL_RESP_ERR_EN is defined.
module pll_phase_shift_responder #(
  parameter int N_COUNTERS  = 5,
  parameter int TAP_W       = 8,
  parameter int LOCK_CYCLES = 16,
  parameter int BUSY_CYCLES = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  pll_phase_shift_responder_if.slave     pif
);

  localparam int LOCK_W = $clog2(LOCK_CYCLES + 1);
  localparam int BUSY_W = $clog2(BUSY_CYCLES + 1);

  typedef enum logic [2:0] {
    LOCKING,
    IDLE,
    ARM,
    BUSY,
    RELEASE
  } state_t;

  state_t             state_q, state_d;
  logic [LOCK_W-1:0]  lock_cnt_q, lock_cnt_d;
  logic [BUSY_W-1:0]  busy_cnt_q, busy_cnt_d;
  logic [4:0]         sel_q, sel_d;
  logic               dir_q, dir_d;
  logic               en_q;
  logic               locked_q, locked_d;
  logic               done_q, done_d;
  logic [TAP_W-1:0]   tap_q [N_COUNTERS];
  logic [TAP_W-1:0]   tap_d [N_COUNTERS];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= LOCKING;
      lock_cnt_q <= '0;
      busy_cnt_q <= '0;
      sel_q      <= '0;
      dir_q      <= 1'b0;
      en_q       <= 1'b0;
      locked_q   <= 1'b0;
      done_q     <= 1'b1;
      for (int i = 0; i < N_COUNTERS; i++) tap_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      lock_cnt_q <= lock_cnt_d;
      busy_cnt_q <= busy_cnt_d;
      sel_q      <= sel_d;
      dir_q      <= dir_d;
      en_q       <= pif.phase_en;
      locked_q   <= locked_d;
      done_q     <= done_d;
      for (int i = 0; i < N_COUNTERS; i++) tap_q[i] <= tap_d[i];
    end
  end

  always_comb begin
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
    busy_cnt_d = busy_cnt_q;
    sel_d      = sel_q;
    dir_d      = dir_q;
    locked_d   = locked_q;
    done_d     = done_q;
    for (int i = 0; i < N_COUNTERS; i++) tap_d[i] = tap_q[i];

    case (state_q)
      LOCKING: begin
        if (lock_cnt_q == LOCK_W'(LOCK_CYCLES - 1)) begin
          locked_d = 1'b1;
          state_d  = IDLE;
        end else begin
          lock_cnt_d = lock_cnt_q + LOCK_W'(1);
        end
      end
      IDLE: begin
        // Rising edge only, so a level left high after lock cannot start a shift
        if (pif.phase_en && !en_q) state_d = ARM;
      end
      ARM: begin
        if (pif.phase_en) begin
          sel_d      = pif.cntsel;
          dir_d      = pif.updn;
          busy_cnt_d = '0;
          done_d     = 1'b0;
          state_d    = BUSY;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (busy_cnt_q == BUSY_W'(BUSY_CYCLES - 1)) begin
          done_d  = 1'b1;
          state_d = RELEASE;
          // Out-of-range selects match no counter and leave every tap alone
          for (int i = 0; i < N_COUNTERS; i++) begin
            if (32'(sel_q) == i)
              tap_d[i] = dir_q ? tap_q[i] + TAP_W'(1) : tap_q[i] - TAP_W'(1);
          end
        end else begin
          busy_cnt_d = busy_cnt_q + BUSY_W'(1);
        end
      end
      RELEASE: begin
        if (!pif.phase_en) state_d = IDLE;
      end
      default: state_d = LOCKING;
    endcase
  end

  assign pif.locked     = locked_q;
  assign pif.phase_done = done_q;

  for (genvar g = 0; g < N_COUNTERS; g++) begin : g_taps
    assign pif.taps[g*TAP_W +: TAP_W] = tap_q[g];
  end

`ifdef PLL_RESP_ERR_EN
  logic err_q;
  logic err_set;

  always_comb begin
    err_set = 1'b0;
    case (state_q)
      LOCKING: err_set = pif.phase_en;
      ARM:     err_set = !pif.phase_en || (32'(pif.cntsel) >= N_COUNTERS);
      default: err_set = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)        err_q <= 1'b0;
    else if (err_set) err_q <= 1'b1;
  end

  assign pif.err = err_q;
`else
  assign pif.err = 1'b0;
`endif

endmodule

// File: tb/tb_pll_phase_shift_responder.sv
// tb/tb_pll_phase_shift_responder.sv - scoreboard bench for pll_phase_shift_responder
// Expected completions are queued at issue time and checked when phase_done rises.
module tb_pll_phase_shift_responder;
  localparam int N    = 5;
  localparam int TW   = 8;
  localparam int LOCK = 16;
  localparam int BUSY = 4;
`ifdef PLL_RESP_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pll_phase_shift_responder_if #(.N_COUNTERS(N), .TAP_W(TW)) pif ();

  pll_phase_shift_responder #(
    .N_COUNTERS(N), .TAP_W(TW), .LOCK_CYCLES(LOCK), .BUSY_CYCLES(BUSY)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .pif   (pif)
  );

  typedef struct {
    logic [N*TW-1:0] taps;
    logic            err;
  } exp_t;

  exp_t            sb[$];
  exp_t            mon_e;
  logic [TW-1:0]   m_taps [N];
  logic            m_err;
  int              checks = 0;
  int              errors = 0;
  int              low_cnt = 0;
  logic            prev_done = 1'b1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [N*TW-1:0] pack_taps();
    logic [N*TW-1:0] v;
    for (int i = 0; i < N; i++) v[i*TW +: TW] = m_taps[i];
    return v;
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      sb.delete();
      low_cnt   = 0;
      prev_done = 1'b1;
    end else begin
      if (pif.phase_done === 1'b0) begin
        low_cnt++;
      end else if (!prev_done) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got completion, expected none queued");
        end else begin
          mon_e = sb.pop_front();
          check("busy_len", 64'(low_cnt), 64'(BUSY));
          check("done_taps", 64'(pif.taps), 64'(mon_e.taps));
          check("done_err", 64'(pif.err), 64'(mon_e.err));
        end
        low_cnt = 0;
      end
      prev_done = pif.phase_done;
    end
  end

  task automatic reset_and_lock();
    reset        = 1'b1;
    pif.phase_en = 1'b0;
    tick(2);
    check("rst_locked", 64'(pif.locked), 64'(0));
    check("rst_done", 64'(pif.phase_done), 64'(1));
    check("rst_taps", 64'(pif.taps), 64'(0));
    check("rst_err", 64'(pif.err), 64'(0));
    for (int i = 0; i < N; i++) m_taps[i] = '0;
    m_err = 1'b0;
    reset = 1'b0;
    for (int e = 0; e < LOCK; e++) begin
      tick(1);
      check($sformatf("locked_e%0d", e), 64'(pif.locked), 64'(e >= LOCK - 1));
      check($sformatf("done_e%0d", e), 64'(pif.phase_done), 64'(1));
    end
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (pif.phase_done !== 1'b1 && n < 20) begin
      tick(1);
      n++;
    end
    if (n >= 20) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got phase_done=%b, expected 1 within 20 cycles", pif.phase_done);
    end
    tick(1);
  endtask

  task automatic issue(input logic [4:0] sel, input logic up, input bit hold);
    exp_t e;
    if (sel < N) m_taps[sel] = up ? TW'(m_taps[sel] + 8'd1) : TW'(m_taps[sel] - 8'd1);
    else if (ERR_EN) m_err = 1'b1;
    e.taps = pack_taps();
    e.err  = m_err;
    sb.push_back(e);
    pif.cntsel   = sel;
    pif.updn     = up;
    pif.phase_en = 1'b1;
    tick(2);
    check("busy_start", 64'(pif.phase_done), 64'(0));
    if (!hold) pif.phase_en = 1'b0;
    wait_done();
  endtask

  task automatic runt(input logic [4:0] sel);
    pif.cntsel   = sel;
    pif.updn     = 1'b1;
    pif.phase_en = 1'b1;
    tick(1);
    pif.phase_en = 1'b0;
    if (ERR_EN) m_err = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick(1);
      check("runt_done", 64'(pif.phase_done), 64'(1));
      check("runt_taps", 64'(pif.taps), 64'(pack_taps()));
    end
    check("runt_err", 64'(pif.err), 64'(m_err));
  endtask

  initial begin
    reset        = 1'b1;
    pif.phase_en = 1'b0;
    pif.updn     = 1'b0;
    pif.cntsel   = '0;
    reset_and_lock();

    issue(5'd1, 1'b1, 1'b0);
    check("tap1_up", 64'(pif.taps), 64'h00_00_00_01_00);
    issue(5'd1, 1'b0, 1'b0);
    issue(5'd1, 1'b0, 1'b0);
    check("tap1_wrap_down", 64'(pif.taps[15:8]), 64'hFF);
    for (int i = 0; i < 256; i++) issue(5'd1, 1'b1, 1'b0);
    check("tap1_wrap_up", 64'(pif.taps[15:8]), 64'hFF);
    issue(5'd0, 1'b1, 1'b0);
    issue(5'd4, 1'b0, 1'b0);
    check("taps_mix", 64'(pif.taps), 64'hFF_00_00_FF_01);

    issue(5'd3, 1'b1, 1'b1);
    for (int i = 0; i < 10; i++) begin
      tick(1);
      check("hold_done", 64'(pif.phase_done), 64'(1));
      check("hold_taps", 64'(pif.taps), 64'(pack_taps()));
    end
    pif.phase_en = 1'b0;
    tick(2);
    issue(5'd3, 1'b1, 1'b0);
    check("tap3_after_hold", 64'(pif.taps[31:24]), 64'h02);

    issue(5'd7, 1'b1, 1'b0);
    check("illegal_taps", 64'(pif.taps), 64'hFF_02_00_FF_01);
    check("illegal_err", 64'(pif.err), 64'(ERR_EN));

    pif.cntsel   = 5'd2;
    pif.updn     = 1'b1;
    pif.phase_en = 1'b1;
    tick(2);
    pif.phase_en = 1'b0;
    tick(1);
    reset = 1'b1;
    #1;
    check("midrst_done", 64'(pif.phase_done), 64'(1));
    check("midrst_taps", 64'(pif.taps), 64'(0));
    check("midrst_locked", 64'(pif.locked), 64'(0));
    check("midrst_err", 64'(pif.err), 64'(0));
    reset_and_lock();
    for (int i = 0; i < 8; i++) begin
      tick(1);
      check("no_stale_taps", 64'(pif.taps), 64'(0));
    end

    runt(5'd2);
    issue(5'd2, 1'b0, 1'b0);
    check("tap2_after_runt", 64'(pif.taps), 64'h00_00_FF_00_00);

    tick(3);
    check("sb_drained", 64'(sb.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish before 200000");
    $fatal(1);
  end
endmodule
